// File: rtl/tmc_spi_xfer.sv
// tmc_spi_xfer: SPI mode-3 master that moves one 40-bit TMC datagram per csn frame.
// Full duplex: mosi shifts out MSB first while miso is sampled on every sclk rising edge.
module tmc_spi_xfer #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GAP   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [39:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [39:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        sclk,
    output logic        csn,
    output logic        mosi,
    input  logic        miso
);

    // state | meaning
    // IDLE  | csn high, waiting for tx_valid
    // SETUP | csn low, bit 39 on mosi, sclk high for CS_SETUP cycles
    // SHIFT | 40 sclk periods, low half then high half
    // HOLD  | csn low, sclk high for CLK_DIV cycles after the last bit
    // GAP   | csn high for CS_GAP cycles before the next frame
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [5:0]  bit_cnt;
    logic [38:0] tx_sr;
    logic [39:0] rx_sr;
    logic        armed;

    // armed keeps tx_ready low until the first edge after reset release
    assign tx_ready = armed & (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            bit_cnt  <= 6'd0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b1;
            csn      <= 1'b1;
            mosi     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed    <= 1'b1;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sr <= tx_data[38:0];
                        mosi  <= tx_data[39];
                        csn   <= 1'b0;
                        sclk  <= 1'b1;
                        cnt   <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        sclk    <= 1'b0;
                        cnt     <= DIV_LD;
                        bit_cnt <= 6'd39;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (!sclk) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[38:0], miso};
                        cnt   <= DIV_LD;
                    end else if (bit_cnt == 6'd0) begin
                        cnt   <= DIV_LD;
                        state <= HOLD;
                    end else begin
                        // falling edge of the next period carries the next bit
                        sclk    <= 1'b0;
                        mosi    <= tx_sr[38];
                        tx_sr   <= {tx_sr[37:0], 1'b0};
                        bit_cnt <= bit_cnt - 6'd1;
                        cnt     <= DIV_LD;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        csn      <= 1'b1;
                        mosi     <= 1'b0;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        cnt      <= GAP_LD;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tmc_spi_xfer.md
TMC_SPI_XFER -- requirements
Module: tmc_spi_xfer

Interface
REQ-001 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CS_SETUP, default 2: clk cycles csn is low before the first sclk falling edge; legal range 1..255.
REQ-003 Parameter CS_GAP, default 8: minimum clk cycles csn is high between frames; legal range 1..255.
REQ-004 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 Port tx_data  input  40  datagram to send: [39:32] address/RW byte, [31:0] data.
REQ-007 Port tx_valid  input  1  tx_data is valid.
REQ-008 Port tx_ready  output  1  engine can accept a datagram.
REQ-009 Port rx_data  output  40  datagram received on miso: [39:32] TMC status byte, [31:0] data.
REQ-010 Port rx_valid  output  1  one-cycle strobe; rx_data is new.
REQ-011 Port busy  output  1  a frame or inter-frame gap is in progress.
REQ-012 Port sclk  output  1  SPI clock, mode 3 (idles high).
REQ-013 Port csn  output  1  SPI chip select, active-low.
REQ-014 Port mosi  output  1  SPI data out, MSB first.
REQ-015 Port miso  input  1  SPI data in; already synchronous to the frame timing, no extra synchronizer.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP, with the transitions IDLE->SETUP->SHIFT->HOLD->GAP->IDLE.
REQ-017 tx_ready SHALL be 1 only in IDLE. A transfer SHALL be accepted on a clk edge where tx_valid and tx_ready are both 1. tx_data SHALL be latched into a 40-bit shift register on that edge.
REQ-018 On the accept edge the engine SHALL enter SETUP: csn=0, mosi=tx_data[39], sclk=1, for CS_SETUP cycles.
REQ-019 SHIFT SHALL produce 40 sclk periods. Each period is CLK_DIV cycles with sclk=0, followed by CLK_DIV cycles with sclk=1.
REQ-020 mosi SHALL change only coincident with sclk falling. Bit 39 is presented in SETUP; bit 39-n is presented at the falling edge of period n (n=1..39).
REQ-021 miso SHALL be sampled on the clk edge that drives sclk 0->1. It SHALL be shifted into the LSB of the receive register; the first sample lands in rx_data[39] after 40 shifts.
REQ-022 After the high half of period 40, HOLD SHALL keep csn=0 and sclk=1 for CLK_DIV cycles.
REQ-023 On exit from HOLD, on one edge: csn->1, rx_data updated, rx_valid=1 for exactly one cycle, mosi->0.
REQ-024 GAP SHALL keep csn=1 for CS_GAP cycles, then return to IDLE.
REQ-025 Frame length SHALL be CS_SETUP + 81*CLK_DIV cycles with csn low. Accept-to-accept minimum SHALL be that value plus CS_GAP plus 1.
REQ-026 busy SHALL be 1 in SETUP, SHIFT, HOLD and GAP; busy SHALL equal ~tx_ready except during reset.
REQ-027 rx_data SHALL hold its value between rx_valid strobes.
REQ-028 tx_data and tx_valid changes SHALL have no effect outside the accept edge. tx_valid held high SHALL start back-to-back frames separated by exactly CS_GAP+1 idle-csn cycles.
REQ-029 Bit and half-period counters SHALL be sized for 40 bits and a maximum divider of 255. No wrap SHALL occur within the legal parameter range.

Reset
REQ-030 While resetn=0: csn=1, sclk=1, mosi=0, tx_ready=0, rx_valid=0, busy=0, rx_data=0, FSM=IDLE. All counters SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL force the REQ-030 values immediately, without waiting for a clock. The partial frame SHALL be discarded and no rx_valid SHALL be produced.
REQ-032 tx_ready SHALL rise on the first clk edge after resetn deasserts.

Verification
REQ-033 CLK_DIV=4, CS_SETUP=2, CS_GAP=8; tx_data=0x8000000001; miso looped to mosi -> rx_valid once with rx_data=0x8000000001; csn low for exactly 326 cycles; 40 sclk rising edges.
REQ-034 tx_data=0x2100000000 with a miso model returning 0x09DEADBEEF -> rx_data=0x09DEADBEEF. The mosi bit stream captured on sclk rising edges equals 0x2100000000.
REQ-035 tx_valid held high for 3 frames -> three rx_valid strobes. Each csn-high gap is 9 cycles, and tx_ready is high for exactly one cycle per acceptance.
REQ-036 resetn pulled low at SHIFT bit 20 -> csn=1 and sclk=1 in the same cycle, no rx_valid. A new frame after release completes correctly.
REQ-037 CLK_DIV=1, CS_SETUP=1, CS_GAP=1 -> csn low for 82 cycles, sclk toggles every cycle, loopback data is intact.
REQ-038 tx_valid asserted during GAP -> no acceptance until IDLE. csn never falls before CS_GAP high cycles have elapsed.
